// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID pipeline register with stall, branch flush and HLT stop
module fetch_stage #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0] BUBBLE      = 16'h0000,
    parameter logic [3:0]             HLT_OPCODE  = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc_plus2,
    output logic                   if_id_valid,
    output logic                   halted
);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus2;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                fetched_hlt;
    logic                unused_bt_lsb;

    // Instructions are 2-byte aligned, so the target's LSB is forced to zero.
    assign redirect_pc   = {branch_target[PC_WIDTH-1:1], 1'b0};
    assign unused_bt_lsb = branch_target[0];
    assign pc_plus2      = pc + PC_WIDTH'(2);
    assign fetched_hlt   = (imem_data[INSTR_WIDTH-1 -: 4] == HLT_OPCODE);
    assign imem_addr     = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= BUBBLE;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else if (stall) begin
            pc             <= pc;
            if_id_instr    <= if_id_instr;
            if_id_pc_plus2 <= if_id_pc_plus2;
            if_id_valid    <= if_id_valid;
            halted         <= halted;
        end else if (flush) begin
            // A taken branch also releases a HLT that sat in its shadow.
            pc             <= redirect_pc;
            if_id_instr    <= BUBBLE;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else if (halted) begin
            pc             <= pc;
            if_id_instr    <= BUBBLE;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b1;
        end else begin
            // The HLT word itself still goes to ID so it can retire.
            pc             <= fetched_hlt ? pc : pc_plus2;
            if_id_instr    <= imem_data;
            if_id_pc_plus2 <= pc_plus2;
            if_id_valid    <= 1'b1;
            halted         <= fetched_hlt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    logic [15:0] mem [0:32767];

    int tests = 0;
    int fails = 0;

    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;
    logic        m_halted;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[15:1]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", {16'h0, imem_addr}, {16'h0, m_pc});
        chk("if_id_instr", {16'h0, if_id_instr}, {16'h0, m_instr});
        chk("if_id_pc_plus2", {16'h0, if_id_pc_plus2}, {16'h0, m_pp2});
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        chk("halted", {31'h0, halted}, {31'h0, m_halted});
    endtask

    // Reference: what one clock edge does, in plain terms of the fetch rules.
    task automatic step(input logic r, input logic s, input logic f, input logic [15:0] bt);
        logic [15:0] word;
        rst = r; stall = s; flush = f; branch_target = bt;
        word = mem[m_pc[15:1]];
        if (r) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 0; m_halted = 0;
        end else if (s) begin
            // everything frozen
        end else if (f) begin
            m_pc = bt & 16'hFFFE; m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 0;
        end else begin
            m_instr = word;
            m_pp2   = 16'((int'(m_pc) + 2) % 65536);
            m_valid = 1;
            if (word[15:12] == 4'hF) m_halted = 1;
            else m_pc = m_pp2;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'hE;
        end
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        mem[16'h0010 >> 1] = 16'hF000;
        rst = 1; stall = 0; flush = 0; branch_target = 16'h0;
        m_pc = 'x; m_instr = 'x; m_pp2 = 'x; m_valid = 'x; m_halted = 'x;

        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        // sequential fetch, then stall at PC=4
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        step(0, 1, 1, 16'h0100);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        // branch redirect with odd target
        step(0, 0, 1, 16'h0041);
        step(0, 0, 0, 16'h0);
        // stall beats flush, then flush redirects
        step(0, 0, 1, 16'h000C);
        step(0, 1, 1, 16'h0200);
        step(0, 0, 1, 16'h0200);
        step(0, 0, 1, 16'h0010);
        // HLT squashed by a same-cycle flush
        step(0, 0, 1, 16'h0030);
        step(0, 0, 1, 16'h0010);
        // HLT fetched normally, then bubbles, stall while halted, flush releases
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        step(0, 0, 1, 16'h0020);
        step(0, 0, 0, 16'h0);
        // PC wrap at top of address space
        step(0, 0, 1, 16'hFFFA);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0);
        // reset while halted and stalled
        step(0, 0, 1, 16'h0010);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(1, 1, 1, 16'h0040);
        step(0, 0, 0, 16'h0);

        // randomized phase with scattered HLTs
        for (int i = 0; i < 40; i++) mem[$urandom_range(0, 255)][15:12] = 4'hF;
        for (int i = 0; i < 400; i++) begin
            logic r, s, f;
            logic [15:0] bt;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 20);
            f  = ($urandom_range(0, 99) < 12);
            bt = 16'($urandom_range(0, 511));
            if ($urandom_range(0, 9) == 0) bt = 16'($urandom);
            step(r, s, f, bt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
